conv_out_streamer: RTL and testbench
====================================

CONV_OUT_STREAMER -- requirements
Module: conv_out_streamer

Interface
REQ-001 SHALL have parameter SIZE, default 100, input matrix edge length of the upstream convolution.
REQ-002 SHALL have parameter SIZEKer, default 3, kernel edge length; result edge N = SIZE-SIZEKer+1.
REQ-003 SHALL have parameter WIDTH_BIT, default 16, signed width of each result element.
REQ-004 SHALL have parameter OUT_BIT, default 8, signed width of each streamed sample.
REQ-005 SHALL have parameter SHIFT, default 0, arithmetic right shift applied before saturation.
REQ-006 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port nreset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  level; upstream done flag, result matrix valid and stable while high.
REQ-009 SHALL have port convIxKernelOut  input  signed [WIDTH_BIT-1:0] [N-1:0][N-1:0]  result matrix.
REQ-010 SHALL have port out_data  output  signed [OUT_BIT-1:0]  streamed sample.
REQ-011 SHALL have port out_valid  output  1  sample valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts sample.
REQ-013 SHALL have port out_last  output  1  high with final sample [N-1][N-1].
REQ-014 SHALL have ports out_row, out_col  output  $clog2(N) each  index of current sample.
REQ-015 SHALL have port busy  output  1  high in STREAM.
REQ-016 SHALL have port finished  output  1  one-cycle pulse after final handshake.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, FINISH, REARM.
REQ-018 IDLE: start=1 at edge k SHALL enter STREAM with out_valid=1, row=col=0 and sample [0][0] registered at edge k+1 (latency 1).
REQ-019 STREAM: handshake = out_valid & out_ready at a rising edge; on handshake SHALL advance row-major (col increments; col=N-1 wraps to 0 and row increments).
REQ-020 STREAM: without handshake, out_data, out_row, out_col, out_last SHALL remain stable; out_valid SHALL not drop.
REQ-021 STREAM: back-to-back handshakes SHALL sustain one sample per cycle.
REQ-022 out_last SHALL be 1 exactly when row=col=N-1 and out_valid=1.
REQ-023 Handshake with out_last=1 SHALL enter FINISH, clear out_valid; FINISH SHALL assert finished for one cycle then go to REARM.
REQ-024 REARM SHALL wait for start=0, then go to IDLE; a start held high SHALL NOT trigger a second run.
REQ-025 start deasserting during STREAM SHALL be ignored (run completes); start changes outside IDLE/REARM have no effect.
REQ-026 Sample = saturate(element >>> SHIFT) to [-2^(OUT_BIT-1), 2^(OUT_BIT-1)-1]; shift is arithmetic (sign-preserving).
REQ-027 All outputs SHALL be registered; no combinational path from out_ready to out_valid.
REQ-028 N=1 SHALL yield one sample with out_last=1.

Reset
REQ-029 nreset=0 SHALL asynchronously force state IDLE, out_valid=0, out_last=0, busy=0, finished=0, out_data=0, out_row=0, out_col=0.
REQ-030 Reset mid-STREAM SHALL abort the run; after release a new run SHALL require start=1 in IDLE and restart at [0][0].

Structure
REQ-031 Package conv_pkg SHALL hold the FSM state enum and default SIZE/SIZEKer/WIDTH_BIT values shared with conv2.
REQ-032 Shift-and-saturate SHALL be a combinational sub-module conv_sat (params WIDTH_BIT, OUT_BIT, SHIFT).

Verification (SIZE=5, SIZEKer=3, N=3, OUT_BIT=8, SHIFT=0)
REQ-033 Matrix 1..9 row-major, out_ready=1, start pulse held -> nine samples 1..9 on consecutive cycles, out_last on 9, finished one cycle later, no rerun while start stays 1.
REQ-034 out_ready toggling 1,0,0,1,... -> each sample held stable while stalled; sequence 1..9 unchanged, no drops or duplicates.
REQ-035 Elements 300, -300, 127, -128, -1 -> samples 127, -128, 127, -128, -1; with SHIFT=2 element -7 -> -2.
REQ-036 nreset=0 after third handshake -> outputs zero immediately; restart after start low-then-high begins at [0][0] value 1.
REQ-037 start deasserted at second sample -> run completes all nine samples, then IDLE without REARM wait.
REQ-038 SIZE=3 (N=1), element -5 -> single sample -5 with out_last=1, finished pulse next cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: streamer FSM states and the
// default geometry/width used by conv2 and its output streamer.
package conv_pkg;

   localparam int unsigned DEF_SIZE      = 100;
   localparam int unsigned DEF_SIZE_KER  = 3;
   localparam int unsigned DEF_WIDTH_BIT = 16;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StFinish,
      StRearm
   } stream_state_e;

endpackage

// File: rtl/conv_sat.sv
// Arithmetic right shift followed by saturation of a signed result element to
// the signed range of one streamed sample.
module conv_sat #(
   parameter int unsigned WIDTH_BIT = 16,
   parameter int unsigned OUT_BIT   = 8,
   parameter int unsigned SHIFT     = 0
) (
   input  logic signed [WIDTH_BIT-1:0] elem_i,
   output logic signed [OUT_BIT-1:0]   sample_o
);

   // One guard bit above the wider of the two widths keeps the clamp compare exact.
   localparam int unsigned EW = ((WIDTH_BIT > OUT_BIT) ? WIDTH_BIT : OUT_BIT) + 1;
   localparam logic signed [EW-1:0] SAT_MAX = EW'((longint'(1) << (OUT_BIT - 1)) - 1);
   localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [WIDTH_BIT-1:0] shifted;
   logic signed [EW-1:0]        ext;

   always_comb begin
      shifted = elem_i >>> SHIFT;
      ext     = {{(EW - WIDTH_BIT){shifted[WIDTH_BIT-1]}}, shifted};
      if (ext > SAT_MAX) begin
         sample_o = SAT_MAX[OUT_BIT-1:0];
      end else if (ext < SAT_MIN) begin
         sample_o = SAT_MIN[OUT_BIT-1:0];
      end else begin
         sample_o = ext[OUT_BIT-1:0];
      end
   end

endmodule

// File: rtl/conv_out_streamer.sv
// Streams a finished N x N convolution result row-major over a valid/ready
// interface, one shifted-and-saturated sample per handshake.
module conv_out_streamer
   import conv_pkg::*;
#(
   parameter int unsigned SIZE      = DEF_SIZE,
   parameter int unsigned SIZEKer   = DEF_SIZE_KER,
   parameter int unsigned WIDTH_BIT = DEF_WIDTH_BIT,
   parameter int unsigned OUT_BIT   = 8,
   parameter int unsigned SHIFT     = 0,
   localparam int unsigned N        = SIZE - SIZEKer + 1,
   localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                                       clock,
   input  logic                                       nreset,
   input  logic                                       start,
   input  logic signed [N-1:0][N-1:0][WIDTH_BIT-1:0]  convIxKernelOut,
   output logic signed [OUT_BIT-1:0]                  out_data,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic                                       out_last,
   output logic        [IDX_W-1:0]                    out_row,
   output logic        [IDX_W-1:0]                    out_col,
   output logic                                       busy,
   output logic                                       finished
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   stream_state_e               state_q;
   logic                        valid_q, last_q, busy_q, finished_q;
   logic        [IDX_W-1:0]     row_q, col_q;
   logic signed [OUT_BIT-1:0]   data_q;

   logic                        hs;
   logic        [IDX_W-1:0]     nxt_row, nxt_col;
   logic signed [WIDTH_BIT-1:0] elem;
   logic signed [OUT_BIT-1:0]   sample;

   // Index of the sample to present after this edge; [0][0] when launching from IDLE.
   always_comb begin
      hs      = valid_q & out_ready;
      nxt_row = '0;
      nxt_col = '0;
      if (state_q == StStream) begin
         if (col_q == LAST_IDX) begin
            nxt_row = row_q + 1'b1;
         end else begin
            nxt_row = row_q;
            nxt_col = col_q + 1'b1;
         end
      end
      elem = convIxKernelOut[nxt_row][nxt_col];
   end

   conv_sat #(
      .WIDTH_BIT (WIDTH_BIT),
      .OUT_BIT   (OUT_BIT),
      .SHIFT     (SHIFT)
   ) u_sat (
      .elem_i   (elem),
      .sample_o (sample)
   );

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q    <= StIdle;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         data_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
      end else begin
         finished_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StStream;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  row_q   <= '0;
                  col_q   <= '0;
                  data_q  <= sample;
                  last_q  <= (N == 1);
               end
            end
            StStream: begin
               if (hs) begin
                  if (last_q) begin
                     state_q    <= StFinish;
                     valid_q    <= 1'b0;
                     last_q     <= 1'b0;
                     busy_q     <= 1'b0;
                     finished_q <= 1'b1;
                  end else begin
                     row_q  <= nxt_row;
                     col_q  <= nxt_col;
                     data_q <= sample;
                     last_q <= (nxt_row == LAST_IDX) && (nxt_col == LAST_IDX);
                  end
               end
            end
            StFinish: state_q <= StRearm;
            // A start still held from the previous run must drop before re-arming.
            StRearm: begin
               if (!start) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign out_row   = row_q;
   assign out_col   = col_q;
   assign busy      = busy_q;
   assign finished  = finished_q;

endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer: scoreboarded streaming, stalls, saturation,
// mid-run reset, start handling, plus SHIFT=2 and N=1 instances.
module tb_conv_out_streamer;

   typedef struct {
      int data;
      int row;
      int col;
      int last;
   } exp_t;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   always #5 clk = ~clk;

   int   n_pass  = 0;
   int   n_total = 0;
   exp_t sb[$];

   // Main instance: N=3, SHIFT=0
   logic                           start_a = 1'b0;
   logic                           ready_a = 1'b0;
   logic signed [2:0][2:0][15:0]   mat_a;
   logic signed [7:0]              data_a;
   logic                           valid_a, last_a, busy_a, fin_a;
   logic        [1:0]              row_a, col_a;

   // SHIFT=2 instance
   logic                           start_b = 1'b0;
   logic                           ready_b = 1'b0;
   logic signed [2:0][2:0][15:0]   mat_b;
   logic signed [7:0]              data_b;
   logic                           valid_b, last_b, busy_b, fin_b;
   logic        [1:0]              row_b, col_b;

   // N=1 instance
   logic                           start_c = 1'b0;
   logic                           ready_c = 1'b0;
   logic signed [0:0][0:0][15:0]   mat_c;
   logic signed [7:0]              data_c;
   logic                           valid_c, last_c, busy_c, fin_c;
   logic        [0:0]              row_c, col_c;

   conv_out_streamer #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(16), .OUT_BIT(8), .SHIFT(0)) u_dut_a (
      .clock(clk), .nreset(nreset), .start(start_a), .convIxKernelOut(mat_a),
      .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .out_last(last_a),
      .out_row(row_a), .out_col(col_a), .busy(busy_a), .finished(fin_a)
   );

   conv_out_streamer #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(16), .OUT_BIT(8), .SHIFT(2)) u_dut_b (
      .clock(clk), .nreset(nreset), .start(start_b), .convIxKernelOut(mat_b),
      .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .out_last(last_b),
      .out_row(row_b), .out_col(col_b), .busy(busy_b), .finished(fin_b)
   );

   conv_out_streamer #(.SIZE(3), .SIZEKer(3), .WIDTH_BIT(16), .OUT_BIT(8), .SHIFT(0)) u_dut_c (
      .clock(clk), .nreset(nreset), .start(start_c), .convIxKernelOut(mat_c),
      .out_data(data_c), .out_valid(valid_c), .out_ready(ready_c), .out_last(last_c),
      .out_row(row_c), .out_col(col_c), .busy(busy_c), .finished(fin_c)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int sat_ref(input int v, input int sh);
      int s;
      s = v >>> sh;
      if (s > 127) return 127;
      if (s < -128) return -128;
      return s;
   endfunction

   task automatic load_a(input int vals[9]);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            mat_a[r][c] = 16'(vals[r*3+c]);
            sb.push_back('{sat_ref(vals[r*3+c], 0), r, c, (r == 2 && c == 2) ? 1 : 0});
         end
      end
   endtask

   // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
   // stop_at > 0 returns right after that many handshakes are committed at a negedge.
   // drop_at > 0 lowers start while sample number drop_at is presented.
   task automatic drain(input int mode, input int stop_at, input int drop_at);
      int cyc = 0;
      int hs  = 0;
      while (sb.size() > 0 && cyc < 60) begin
         @(negedge clk);
         ready_a = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (drop_at > 0 && hs == drop_at - 1) start_a = 1'b0;
         chk("valid_held", int'(valid_a), 1);
         if (valid_a) begin
            chk("data", int'(data_a), sb[0].data);
            chk("row", int'(row_a), sb[0].row);
            chk("col", int'(col_a), sb[0].col);
            chk("last", int'(last_a), sb[0].last);
            chk("busy", int'(busy_a), 1);
            if (ready_a) begin
               void'(sb.pop_front());
               hs++;
            end
         end
         cyc++;
         if (stop_at > 0 && hs == stop_at) break;
      end
      if (stop_at == 0) chk("drain_done", sb.size(), 0);
   endtask

   task automatic chk_finish_a();
      @(negedge clk);
      chk("finished_pulse", int'(fin_a), 1);
      chk("valid_after_last", int'(valid_a), 0);
      chk("busy_after_last", int'(busy_a), 0);
      chk("last_after_last", int'(last_a), 0);
   endtask

   initial begin
      mat_a = '0;
      mat_b = '0;
      mat_c = '0;
      #12;
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_last", int'(last_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      chk("rst_finished", int'(fin_a), 0);
      chk("rst_data", int'(data_a), 0);
      chk("rst_row", int'(row_a), 0);
      chk("rst_col", int'(col_a), 0);
      chk("rst_valid_c", int'(valid_c), 0);
      @(negedge clk);
      nreset = 1'b1;

      // Plain run, start held high afterwards: no rerun
      load_a('{1, 2, 3, 4, 5, 6, 7, 8, 9});
      start_a = 1'b1;
      drain(0, 0, 0);
      chk_finish_a();
      @(negedge clk);
      chk("finished_one_cycle", int'(fin_a), 0);
      repeat (5) begin
         @(negedge clk);
         chk("no_rerun_valid", int'(valid_a), 0);
         chk("no_rerun_busy", int'(busy_a), 0);
      end

      // Stalled run, ready 1,0,0,...
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      load_a('{1, 2, 3, 4, 5, 6, 7, 8, 9});
      start_a = 1'b1;
      drain(1, 0, 0);
      chk_finish_a();

      // Saturation
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      load_a('{300, -300, 127, -128, -1, 0, 1, 2, 3});
      start_a = 1'b1;
      drain(0, 0, 0);
      chk_finish_a();

      // Reset after the third handshake
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      load_a('{1, 2, 3, 4, 5, 6, 7, 8, 9});
      start_a = 1'b1;
      drain(0, 3, 0);
      @(posedge clk);
      #1 nreset = 1'b0;
      #1;
      chk("abort_valid", int'(valid_a), 0);
      chk("abort_data", int'(data_a), 0);
      chk("abort_row", int'(row_a), 0);
      chk("abort_col", int'(col_a), 0);
      chk("abort_busy", int'(busy_a), 0);
      chk("abort_last", int'(last_a), 0);
      sb.delete();
      start_a = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      chk("post_abort_idle", int'(valid_a), 0);
      load_a('{1, 2, 3, 4, 5, 6, 7, 8, 9});
      start_a = 1'b1;
      drain(0, 0, 0);
      chk_finish_a();

      // start dropped at the second sample; next run needs no extra re-arm wait
      start_a = 1'b0;
      repeat (2) @(negedge clk);
      load_a('{1, 2, 3, 4, 5, 6, 7, 8, 9});
      start_a = 1'b1;
      drain(0, 0, 2);
      chk_finish_a();
      @(negedge clk);
      load_a('{9, 8, 7, 6, 5, 4, 3, 2, 1});
      @(negedge clk);
      start_a = 1'b1;
      drain(0, 0, 0);
      chk_finish_a();

      // SHIFT=2
      mat_b[0][0] = -16'sd7;
      mat_b[0][1] = 16'sd1000;
      mat_b[0][2] = -16'sd1000;
      ready_b = 1'b0;
      start_b = 1'b1;
      @(negedge clk);
      chk("shift_valid", int'(valid_b), 1);
      chk("shift_neg7", int'(data_b), sat_ref(-7, 2));
      ready_b = 1'b1;
      @(negedge clk);
      chk("shift_sat_hi", int'(data_b), sat_ref(1000, 2));
      chk("shift_col1", int'(col_b), 1);
      @(negedge clk);
      chk("shift_sat_lo", int'(data_b), sat_ref(-1000, 2));
      chk("shift_busy", int'(busy_b), 1);
      chk("shift_last", int'(last_b), 0);
      ready_b = 1'b0;

      // N=1
      mat_c[0][0] = -16'sd5;
      ready_c = 1'b1;
      start_c = 1'b1;
      @(negedge clk);
      chk("n1_valid", int'(valid_c), 1);
      chk("n1_data", int'(data_c), -5);
      chk("n1_last", int'(last_c), 1);
      chk("n1_rowcol", int'({row_c, col_c}), 0);
      @(negedge clk);
      chk("n1_finished", int'(fin_c), 1);
      chk("n1_valid_after", int'(valid_c), 0);
      chk("n1_busy_after", int'(busy_c), 0);
      @(negedge clk);
      chk("n1_finished_off", int'(fin_c), 0);
      chk("b_row_idle", int'(row_b), 0);
      chk("b_fin_idle", int'(fin_b), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
